complex_integer_divider_unit: RTL

// - Iterative radix-2 divider in the complex-integer execution stage, directly downstream of register read.
// - The issue stage reserves it; register read then starts it with operands, or cancels the

---
 rtl/complex_integer_divider_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/complex_integer_divider_unit.sv
// complex_integer_divider_unit
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the
// complex-integer execution stage. Single-op occupancy: reserved by issue,
// started or cancelled by register read, held until the consumer releases it.
// Optional feature macro: RSD_DIV_EARLY_OUT_EN (divide-by-zero and signed
// overflow skip the iteration loop).
// The consumer-release input is named resultRelease because "release" is a
// reserved word in SystemVerilog.
module complex_integer_divider_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  reserve,
  input  logic                  req,
  input  logic                  reqFlushed,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  isSigned,
  input  logic                  isRem,
  input  logic                  resultRelease,
  output logic                  free,
  output logic                  resultValid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    FREE,
    RESERVED,
    DIVIDING,
    FIXUP,
    FINISHED
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  counter;
  logic [DATA_WIDTH-1:0] part_rem;   // running partial remainder (always < |B|)
  logic [DATA_WIDTH-1:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] abs_b;
  logic                  neg_q;
  logic                  neg_r;
  logic                  rem_sel;

  logic [DATA_WIDTH-1:0] abs_a_in;
  logic [DATA_WIDTH-1:0] abs_b_in;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  step_ok;
  logic [DATA_WIDTH-1:0] fix_q;
  logic [DATA_WIDTH-1:0] fix_r;
  logic [DATA_WIDTH-1:0] fix_result;

`ifdef RSD_DIV_EARLY_OUT_EN
  logic early_hold;
  logic div_zero;
  logic signed_ovf;

  // Special operands whose result is known without iterating.
  always_comb begin
    div_zero   = (divisor == '0);
    signed_ovf = isSigned && (dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (divisor == '1);
  end
`endif

  // Operand magnitudes taken at request time.
  always_comb begin
    abs_a_in = (isSigned && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
    abs_b_in = (isSigned && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract |B| on a
  // DATA_WIDTH+1-bit value, keep the difference when it is non-negative.
  always_comb begin
    shifted = {part_rem, quo[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, abs_b};
    step_ok = ~trial[DATA_WIDTH];
  end

  // Sign correction and quotient/remainder selection.
  always_comb begin
    fix_q      = neg_q ? -quo : quo;
    fix_r      = neg_r ? -part_rem : part_rem;
    fix_result = rem_sel ? fix_r : fix_q;
  end

  // Control FSM with registered status outputs and the iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FREE;
      free        <= 1'b1;
      resultValid <= 1'b0;
      result      <= '0;
      counter     <= '0;
      part_rem    <= '0;
      quo         <= '0;
      abs_b       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem_sel     <= 1'b0;
`ifdef RSD_DIV_EARLY_OUT_EN
      early_hold  <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          if (reserve) begin
            state <= RESERVED;
            free  <= 1'b0;
          end
        end

        RESERVED: begin
          if (reqFlushed) begin
            state <= FREE;
            free  <= 1'b1;
          end else if (req && !stall) begin
            abs_b   <= abs_b_in;
            neg_q   <= isSigned && (dividend[DATA_WIDTH-1] != divisor[DATA_WIDTH-1]) &&
                       (divisor != '0);
            neg_r   <= isSigned && dividend[DATA_WIDTH-1];
            rem_sel <= isRem;
`ifdef RSD_DIV_EARLY_OUT_EN
            if (div_zero || signed_ovf) begin
              // Preload what the full loop would have produced for these operands.
              quo        <= div_zero ? '1 : abs_a_in;
              part_rem   <= div_zero ? abs_a_in : '0;
              counter    <= '0;
              early_hold <= 1'b1;
              state      <= FIXUP;
            end else begin
              quo      <= abs_a_in;
              part_rem <= '0;
              counter  <= CNT_WIDTH'(DATA_WIDTH);
              state    <= DIVIDING;
            end
`else
            quo      <= abs_a_in;
            part_rem <= '0;
            counter  <= CNT_WIDTH'(DATA_WIDTH);
            state    <= DIVIDING;
`endif
          end
        end

        DIVIDING: begin
          if (abort) begin
            state <= FREE;
            free  <= 1'b1;
          end else begin
            part_rem <= step_ok ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            quo      <= {quo[DATA_WIDTH-2:0], step_ok};
            counter  <= counter - 1'b1;
            if (counter == CNT_WIDTH'(1)) begin
              state <= FIXUP;
            end
          end
        end

        FIXUP: begin
          if (abort) begin
            state <= FREE;
            free  <= 1'b1;
          end
`ifdef RSD_DIV_EARLY_OUT_EN
          // Early-out ops spend one extra cycle here so resultValid lands at E0+2.
          else if (early_hold) begin
            early_hold <= 1'b0;
          end
`endif
          else begin
            result      <= fix_result;
            resultValid <= 1'b1;
            state       <= FINISHED;
          end
        end

        FINISHED: begin
          if (abort || (resultRelease && !stall)) begin
            state       <= FREE;
            free        <= 1'b1;
            resultValid <= 1'b0;
          end
        end

        default: begin
          state       <= FREE;
          free        <= 1'b1;
          resultValid <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Reserving an occupied unit is an issue-stage protocol error; it is ignored.
  reserve_only_when_free: assert property (@(posedge clk) disable iff (rst)
    reserve |-> (state == FREE));
`endif

endmodule
